uart_tx: RTL and testbench

//  UART serializer: frames a parallel byte as start/data/[parity]/stop bits on o_tx.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 102 ++++++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encodings, legal parameter ranges and parity helper shared by the UART blocks
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  function automatic logic calc_par(input logic [7:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: baud tick, start/data request and serial line/busy/done status between a UART transmitter and its user
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 i_baud_tick;
  logic                 i_tx_start;
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 o_tx;
  logic                 o_tx_busy;
  logic                 o_tx_done;
  modport master (output i_baud_tick, i_tx_start, i_tx_data, input o_tx, o_tx_busy, o_tx_done);
  modport slave  (input i_baud_tick, i_tx_start, i_tx_data, output o_tx, o_tx_busy, o_tx_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: frames a latched byte as start/data/[parity]/stop bits on a registered idle-high line, one bit per baud tick
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input logic     i_clk,
  input logic     i_rst_n,
  uart_tx_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_params
    $error("uart_tx: DATA_BITS must be 5..8 and STOP_BITS 1..2");
  end
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_tx_start) begin
        shreg_d = bus.i_tx_data;
        cnt_d   = '0;
        stop_d  = 1'b0;
        par_d   = calc_par(8'(bus.i_tx_data), PARITY_ODD);
        busy_d  = 1'b1;
        state_d = SYNC;
      end
      SYNC: if (bus.i_baud_tick) begin
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (bus.i_baud_tick) begin
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        state_d = DATA;
      end
      DATA: if (bus.i_baud_tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_BITS - 1)) begin
          tx_d    = PARITY_EN ? par_q : 1'b1;
          state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      PARITY: if (bus.i_baud_tick) begin
        tx_d    = 1'b1;
        state_d = STOP;
      end
      STOP: if (bus.i_baud_tick) begin
        if (stop_q == 1'(STOP_BITS - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.o_tx      = tx_q;
  assign bus.o_tx_busy = busy_q;
  assign bus.o_tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks 8N1/8E1/8O1/8N2 transmitters against a frame model under table-driven and random traffic
module tb_uart_tx;
  localparam int NU = 4;
  localparam logic [NU-1:0] PE  = 4'b0110;
  localparam logic [NU-1:0] PO  = 4'b0100;
  localparam logic [NU-1:0] SB2 = 4'b1000;
  typedef struct {
    int          u;
    logic [7:0]  d;
    bit          mid;
    logic [11:0] f;
    int          len;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic [NU-1:0] start = '0;
  logic [7:0] data [NU];
  logic [NU-1:0] tx, busy, done;
  int checks = 0;
  int errors = 0;
  vec_t tbl [5];
  for (genvar g = 0; g < NU; g++) begin : u_g
    uart_tx_if #(.DATA_BITS(8)) bus ();
    assign bus.i_baud_tick = tick;
    assign bus.i_tx_start  = start[g];
    assign bus.i_tx_data   = data[g];
    assign tx[g]   = bus.o_tx;
    assign busy[g] = bus.o_tx_busy;
    assign done[g] = bus.o_tx_done;
    uart_tx #(
      .DATA_BITS (8),
      .PARITY_EN (PE[g]),
      .PARITY_ODD(PO[g]),
      .STOP_BITS (SB2[g] ? 2 : 1)
    ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
    );
  end
  always #5 clk = ~clk;
  initial forever begin
    repeat (15) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model(input int u, input logic [7:0] d, output logic [11:0] f, output int len);
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    len = 9;
    if (PE[u]) begin
      f[9] = (^d) ^ PO[u];
      len++;
    end
    len += SB2[u] ? 2 : 1;
  endfunction
  task automatic wait_fall(input int u, output bit ok, output int w);
    w = 0;
    while (tx[u] !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 40);
    chk($sformatf("u%0d fall_seen", u), 32'(ok), 32'd1);
  endtask
  task automatic run_frame(input int u, input logic [7:0] d, input bit mid, input logic [11:0] f, input int len);
    bit ok;
    int w, dn, bl;
    @(negedge clk);
    start[u] = 1'b1;
    data[u] = d;
    @(negedge clk);
    start[u] = 1'b0;
    data[u] = 8'($urandom);
    wait_fall(u, ok, w);
    if (!ok) return;
    dn = 0;
    bl = 0;
    for (int n = 0; n < 16 * len; n++) begin
      if (n % 16 == 8) chk($sformatf("u%0d d%0h bit%0d", u, d, n / 16), 32'(tx[u]), 32'(f[n / 16]));
      dn += int'(done[u]);
      if (busy[u] !== 1'b1) bl++;
      if (mid && n == 40) begin
        start[u] = 1'b1;
        data[u] = 8'h55;
      end
      if (mid && n == 41) start[u] = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("u%0d done_at_end", u), 32'(done[u]), 32'd1);
    chk($sformatf("u%0d busy_at_end", u), 32'(busy[u]), 32'd0);
    chk($sformatf("u%0d tx_at_end", u), 32'(tx[u]), 32'd1);
    chk($sformatf("u%0d done_early", u), 32'(dn), 32'd0);
    chk($sformatf("u%0d busy_gap", u), 32'(bl), 32'd0);
    @(negedge clk);
    chk($sformatf("u%0d done_one_cycle", u), 32'(done[u]), 32'd0);
    chk($sformatf("u%0d no_restart", u), 32'(busy[u]), 32'd0);
  endtask
  initial begin
    bit ok;
    int w, bad, low;
    logic [11:0] f;
    int len, u;
    logic [7:0] d;
    for (int i = 0; i < NU; i++) data[i] = 8'h00;
    tbl[0] = '{0, 8'hA5, 1'b0, {3'b111, 8'hA5, 1'b0}, 10};
    tbl[1] = '{1, 8'h07, 1'b0, {2'b11, 1'b1, 8'h07, 1'b0}, 11};
    tbl[2] = '{2, 8'h07, 1'b0, {2'b11, 1'b0, 8'h07, 1'b0}, 11};
    tbl[3] = '{0, 8'h3C, 1'b1, {3'b111, 8'h3C, 1'b0}, 10};
    tbl[4] = '{3, 8'hFF, 1'b0, {3'b111, 8'hFF, 1'b0}, 11};
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      chk($sformatf("u%0d rst_tx", i), 32'(tx[i]), 32'd1);
      chk($sformatf("u%0d rst_busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("u%0d rst_done", i), 32'(done[i]), 32'd0);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (1600) begin
      @(negedge clk);
      if (tx !== '1 || busy !== '0 || done !== '0) bad++;
    end
    chk("idle_100_ticks", 32'(bad), 32'd0);
    do begin
      @(negedge clk);
      #1;
    end while (!tick);
    start[0] = 1'b1;
    data[0] = 8'hA5;
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    wait_fall(0, ok, w);
    chk("tick_start_fall_delay", 32'(w), 32'd16);
    low = 0;
    while (tx[0] === 1'b0 && low < 40) begin
      @(negedge clk);
      low++;
    end
    chk("start_bit_len", 32'(low), 32'd16);
    w = 0;
    while (done[0] !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("tick_frame_done", 32'(done[0]), 32'd1);
    @(negedge clk);
    start[0] = 1'b1;
    data[0] = 8'h96;
    @(negedge clk);
    start[0] = 1'b0;
    wait_fall(0, ok, w);
    repeat (72) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx", 32'(tx[0]), 32'd1);
    chk("midframe_rst_busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle_tx", 32'(tx[0]), 32'd1);
    for (int i = 0; i < 5; i++) run_frame(tbl[i].u, tbl[i].d, tbl[i].mid, tbl[i].f, tbl[i].len);
    repeat (24) begin
      u = int'($urandom_range(0, NU - 1));
      d = 8'($urandom);
      model(u, d, f, len);
      run_frame(u, d, 1'b0, f, len);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
